// File: rtl/instruction_fetch_unit_if.sv
// Control, instruction-memory and IF/ID signals between the fetch unit and its surroundings.
// The fetch unit connects through the slave modport; its environment uses the master modport.
interface instruction_fetch_unit_if;
  logic        Start;
  logic        Halt;
  logic        Stall;
  logic        Redirect;
  logic [31:0] Target;
  logic [31:0] IMemAddr;
  logic [31:0] IMemData;
  logic        IMemWen;
  logic [31:0] IfId_Instr;
  logic [31:0] IfId_PcPlus4;
  logic        IfId_Valid;
  logic [31:0] PC;
  logic [31:0] FetchCount;
  logic [1:0]  State;

  modport master (
    output Start, Halt, Stall, Redirect, Target, IMemData,
    input  IMemAddr, IMemWen, IfId_Instr, IfId_PcPlus4, IfId_Valid, PC, FetchCount, State
  );

  modport slave (
    input  Start, Halt, Stall, Redirect, Target, IMemData,
    output IMemAddr, IMemWen, IfId_Instr, IfId_PcPlus4, IfId_Valid, PC, FetchCount, State
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Single-issue instruction fetch stage: PC register, IF/ID pipeline register and an
// IDLE/RUN/HALTED sequencer. Priority in RUN is Halt > Redirect > Stall > fetch.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    Clk,
  input  logic                    Rst,
  instruction_fetch_unit_if.slave ifu
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_HALTED = 2'b10,
    S_BAD    = 2'b11
  } state_t;

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic [31:0] count_q, count_d;
  logic        valid_q, valid_d;
  logic        do_fetch, do_redirect, do_halt, clr_valid;
  logic [31:0] pc_plus4;

  // Wraps modulo 2^32 by construction.
  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (ifu.Start) state_d = S_RUN;
      S_RUN:    if (ifu.Halt)  state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    do_fetch    = 1'b0;
    do_redirect = 1'b0;
    do_halt     = 1'b0;
    clr_valid   = 1'b0;
    case (state_q)
      S_IDLE: clr_valid = 1'b1;
      S_RUN: begin
        if (ifu.Halt)          do_halt     = 1'b1;
        else if (ifu.Redirect) do_redirect = 1'b1;
        else if (!ifu.Stall)   do_fetch    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    count_d = count_q;
    if (do_halt || clr_valid) begin
      valid_d = 1'b0;
      if (do_halt) instr_d = 32'd0;
    end
    if (do_redirect) begin
      pc_d    = {ifu.Target[31:2], 2'b00};
      instr_d = 32'd0;
      pcp4_d  = 32'd0;
      valid_d = 1'b0;
    end
    if (do_fetch) begin
      pc_d    = pc_plus4;
      instr_d = ifu.IMemData;
      pcp4_d  = pc_plus4;
      valid_d = 1'b1;
      if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc_q    <= PC_INIT;
      instr_q <= 32'd0;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign ifu.IMemAddr     = {2'b00, pc_q[31:2]};
  assign ifu.IMemWen      = 1'b0;
  assign ifu.IfId_Instr   = instr_q;
  assign ifu.IfId_PcPlus4 = pcp4_q;
  assign ifu.IfId_Valid   = valid_q;
  assign ifu.PC           = pc_q;
  assign ifu.FetchCount   = count_q;
  assign ifu.State        = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized
// control traffic compared against a transaction-level model of the fetch stage.
module tb_instruction_fetch_unit;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  instruction_fetch_unit_if ifu ();
  instruction_fetch_unit_if ifu2 ();

  logic [31:0] mem [256];
  assign ifu.IMemData  = mem[ifu.IMemAddr[7:0]];
  assign ifu2.IMemData = mem[ifu2.IMemAddr[7:0]];

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut      (.Clk(Clk), .Rst(Rst), .ifu(ifu));
  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (.Clk(Clk), .Rst(Rst), .ifu(ifu2));

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: 0 idle, 1 running, 2 halted
  logic [1:0]  m_st;
  logic [31:0] m_pc, m_instr, m_pcp4, m_cnt;
  logic        m_valid;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 2'd0; m_pc = 32'd0; m_instr = 32'd0; m_pcp4 = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;
  endtask

  task automatic model_edge();
    if (m_st == 2'd0) begin
      if (ifu.Start) m_st = 2'd1;
    end else if (m_st == 2'd1) begin
      if (ifu.Halt) begin
        m_st = 2'd2; m_valid = 1'b0; m_instr = 32'd0;
      end else if (ifu.Redirect) begin
        m_pc = ifu.Target & 32'hFFFF_FFFC;
        m_valid = 1'b0; m_instr = 32'd0; m_pcp4 = 32'd0;
      end else if (!ifu.Stall) begin
        m_instr = mem[m_pc[9:2]];
        m_pc    = m_pc + 32'd4;
        m_pcp4  = m_pc;
        m_valid = 1'b1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".state"}, {30'd0, ifu.State}, {30'd0, m_st});
    check({tag, ".pc"},    ifu.PC, m_pc);
    check({tag, ".addr"},  ifu.IMemAddr, m_pc >> 2);
    check({tag, ".instr"}, ifu.IfId_Instr, m_instr);
    check({tag, ".pcp4"},  ifu.IfId_PcPlus4, m_pcp4);
    check({tag, ".valid"}, {31'd0, ifu.IfId_Valid}, {31'd0, m_valid});
    check({tag, ".count"}, ifu.FetchCount, m_cnt);
    check({tag, ".wen"},   {31'd0, ifu.IMemWen}, 32'd0);
  endtask

  task automatic tick(string tag);
    model_edge();
    @(posedge Clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(string tag);
    Rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    check({tag, ".wrap_pc"}, ifu2.PC, 32'hFFFF_FFFC);
    Rst = 1'b0;
  endtask

  task automatic clear_inputs();
    ifu.Start = 1'b0; ifu.Halt = 1'b0; ifu.Stall = 1'b0; ifu.Redirect = 1'b0; ifu.Target = 32'd0;
  endtask

  task automatic start_run();
    ifu.Start = 1'b1;
    tick("start");
    ifu.Start = 1'b0;
  endtask

  initial begin
    Rst = 1'b1;
    clear_inputs();
    ifu2.Start = 1'b0; ifu2.Halt = 1'b0; ifu2.Stall = 1'b0; ifu2.Redirect = 1'b0; ifu2.Target = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;
    for (int i = 0; i < 4; i++) mem[i] = 32'h11 * (i + 1);
    mem[16]  = 32'hDEAD_0016;
    mem[255] = 32'hCAFE_00FF;

    #12;
    model_reset();
    check_all("reset");
    check("reset.wrap_pc", ifu2.PC, 32'hFFFF_FFFC);
    Rst = 1'b0;

    // IDLE ignores everything except Start
    ifu.Redirect = 1'b1; ifu.Target = 32'h80; ifu.Halt = 1'b1;
    tick("idle_ignore");
    clear_inputs();

    ifu2.Start = 1'b1;
    start_run();
    ifu2.Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick("seq");
      check("seq.instr_const", ifu.IfId_Instr, 32'h11 * (i + 1));
      check("seq.pcp4_const", ifu.IfId_PcPlus4, 32'(4 * (i + 1)));
      if (i == 0) begin
        check("wrap.pc", ifu2.PC, 32'd0);
        check("wrap.pcp4", ifu2.IfId_PcPlus4, 32'd0);
        check("wrap.instr", ifu2.IfId_Instr, 32'hCAFE_00FF);
      end
    end
    check("seq.count_const", ifu.FetchCount, 32'd4);

    // stall at PC=8
    do_reset("rst2");
    start_run();
    tick("pre_stall");
    tick("pre_stall");
    ifu.Stall = 1'b1;
    tick("stall");
    tick("stall");
    check("stall.pc_const", ifu.PC, 32'd8);
    check("stall.count_const", ifu.FetchCount, 32'd2);
    ifu.Stall = 1'b0;
    tick("resume");
    check("resume.instr_const", ifu.IfId_Instr, 32'h33);

    // redirect wins over stall, target low bits dropped
    ifu.Redirect = 1'b1; ifu.Stall = 1'b1; ifu.Target = 32'h43;
    tick("redir");
    check("redir.pc_const", ifu.PC, 32'h40);
    clear_inputs();
    tick("redir_fetch");
    check("redir.instr_const", ifu.IfId_Instr, 32'hDEAD_0016);
    check("redir.pcp4_const", ifu.IfId_PcPlus4, 32'h44);

    // halt wins over redirect and is sticky
    ifu.Halt = 1'b1; ifu.Redirect = 1'b1; ifu.Target = 32'h100;
    tick("halt");
    check("halt.state_const", {30'd0, ifu.State}, 32'd2);
    check("halt.pc_const", ifu.PC, 32'h44);
    clear_inputs();
    ifu.Start = 1'b1; ifu.Redirect = 1'b1; ifu.Target = 32'h200;
    tick("halted_ignore");
    clear_inputs();
    tick("halted_ignore");
    check("halted.pc_const", ifu.PC, 32'h44);

    // async reset between edges mid-run
    do_reset("rst3");
    start_run();
    tick("pre_async");
    tick("pre_async");
    #3;
    Rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst.pc_const", ifu.PC, 32'd0);
    #1;
    Rst = 1'b0;
    for (int i = 0; i < 3; i++) tick("post_async_idle");
    check("post_async.state_const", {30'd0, ifu.State}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset("rnd_rst");
      end else begin
        ifu.Start    = ($urandom_range(0, 9) == 0);
        ifu.Halt     = ($urandom_range(0, 79) == 0);
        ifu.Redirect = ($urandom_range(0, 9) == 0);
        ifu.Stall    = ($urandom_range(0, 4) == 0);
        ifu.Target   = $urandom;
        tick("rnd");
      end
    end
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
